// File: rtl/iic_arbiter.sv
// Two-requester round-robin arbiter in front of a single I2C master.
// Latches the winner's transaction, launches the master and reports completion or launch timeout.
module iic_arbiter #(
  parameter logic [7:0]  WMEN_LEN = 8'd4,
  parameter logic [7:0]  RMEN_LEN = 8'd4,
  parameter logic [31:0] TIMEOUT  = 32'd100000
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [1:0]                req_i,
  input  logic [2*WMEN_LEN*8-1:0]   req_wr_data_i,
  input  logic [15:0]               req_wr_cnt_i,
  input  logic [15:0]               req_rd_cnt_i,
  input  logic [1:0]                req_mode_i,
  output logic [1:0]                grant_o,
  output logic [1:0]                done_o,
  output logic [1:0]                timeout_o,
  output logic [RMEN_LEN*8-1:0]     rd_data_o,
  output logic                      iic_en_o,
  output logic [WMEN_LEN*8-1:0]     iic_wr_data_o,
  output logic [7:0]                iic_wr_cnt_o,
  output logic [7:0]                iic_rd_cnt_o,
  output logic                      iic_mode_o,
  input  logic                      iic_busy_i,
  input  logic [RMEN_LEN*8-1:0]     iic_rd_data_i
);

  localparam int unsigned WB = 32'(WMEN_LEN) * 32'd8;
  localparam int unsigned RB = 32'(RMEN_LEN) * 32'd8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            busy_m, busy_s;
  logic [1:0]      settle_q;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            sel_c;

  logic [1:0]      grant_d, done_d, timeout_d;
  logic            en_d, mode_d;
  logic [WB-1:0]   wr_data_d;
  logic [7:0]      wr_cnt_d, rd_cnt_d;
  logic [RB-1:0]   rd_data_d;

  // Busy comes from the SCL-domain master; settle_q guarantees busy_s reflects it after reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      busy_m   <= 1'b0;
      busy_s   <= 1'b0;
      settle_q <= 2'b00;
    end else begin
      busy_m   <= iic_busy_i;
      busy_s   <= busy_m;
      settle_q <= {settle_q[0], 1'b1};
    end
  end

  // Round-robin pick: on a tie the requester not served last wins.
  assign sel_c = (req_i == 2'b11) ? ~last_q : req_i[1];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      cnt_q         <= 32'd0;
      grant_o       <= 2'b00;
      done_o        <= 2'b00;
      timeout_o     <= 2'b00;
      iic_en_o      <= 1'b0;
      iic_wr_data_o <= '0;
      iic_wr_cnt_o  <= 8'd0;
      iic_rd_cnt_o  <= 8'd0;
      iic_mode_o    <= 1'b0;
      rd_data_o     <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      grant_o       <= grant_d;
      done_o        <= done_d;
      timeout_o     <= timeout_d;
      iic_en_o      <= en_d;
      iic_wr_data_o <= wr_data_d;
      iic_wr_cnt_o  <= wr_cnt_d;
      iic_rd_cnt_o  <= rd_cnt_d;
      iic_mode_o    <= mode_d;
      rd_data_o     <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    grant_d   = grant_o;
    done_d    = 2'b00;
    timeout_d = 2'b00;
    en_d      = 1'b0;
    wr_data_d = iic_wr_data_o;
    wr_cnt_d  = iic_wr_cnt_o;
    rd_cnt_d  = iic_rd_cnt_o;
    mode_d    = iic_mode_o;
    rd_data_d = rd_data_o;

    case (state_q)
      S_IDLE: begin
        if ((|req_i) && settle_q[1] && !busy_s) begin
          owner_d   = sel_c;
          grant_d   = sel_c ? 2'b10 : 2'b01;
          wr_data_d = sel_c ? req_wr_data_i[WB +: WB] : req_wr_data_i[0 +: WB];
          wr_cnt_d  = sel_c ? req_wr_cnt_i[15:8] : req_wr_cnt_i[7:0];
          rd_cnt_d  = sel_c ? req_rd_cnt_i[15:8] : req_rd_cnt_i[7:0];
          mode_d    = sel_c ? req_mode_i[1] : req_mode_i[0];
          en_d      = 1'b1;
          cnt_d     = 32'd0;
          state_d   = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        if (busy_s) begin
          state_d = S_ACTIVE;
        end else if ((TIMEOUT != 32'd0) && (cnt_q == TIMEOUT - 32'd1)) begin
          timeout_d[owner_q] = 1'b1;
          grant_d            = 2'b00;
          last_d             = owner_q;
          state_d            = S_IDLE;
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt_q + 32'd1;
        end
      end

      // Busy stays high across a random-read restart, so only its fall ends the transfer.
      S_ACTIVE: begin
        if (!busy_s) begin
          done_d[owner_q] = 1'b1;
          grant_d         = 2'b00;
          rd_data_d       = iic_rd_data_i;
          last_d          = owner_q;
          state_d         = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iic_arbiter.sv
// Randomized scoreboard bench for iic_arbiter with a behavioural I2C master and round-robin model.
`timescale 1ns/1ps
module tb_iic_arbiter;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req_i = 2'b00;
  logic [63:0] req_wr_data = '0;
  logic [15:0] req_wr_cnt = '0;
  logic [15:0] req_rd_cnt = '0;
  logic [1:0]  req_mode = '0;
  logic [1:0]  grant_o, done_o, timeout_o;
  logic [31:0] rd_data_o;
  logic        iic_en_o;
  logic [31:0] iic_wr_data_o;
  logic [7:0]  iic_wr_cnt_o, iic_rd_cnt_o;
  logic        iic_mode_o;
  logic        iic_busy_i;
  logic [31:0] iic_rd_data_i;

  logic        slv_busy, man_busy = 1'b0;
  bit          manual = 1'b0, silent = 1'b0;
  assign iic_busy_i = manual ? man_busy : slv_busy;

  iic_arbiter #(.WMEN_LEN(8'd4), .RMEN_LEN(8'd4), .TIMEOUT(32'(TO))) dut (
    .clk_i(clk), .rstn_i(rstn), .req_i(req_i), .req_wr_data_i(req_wr_data),
    .req_wr_cnt_i(req_wr_cnt), .req_rd_cnt_i(req_rd_cnt), .req_mode_i(req_mode),
    .grant_o(grant_o), .done_o(done_o), .timeout_o(timeout_o), .rd_data_o(rd_data_o),
    .iic_en_o(iic_en_o), .iic_wr_data_o(iic_wr_data_o), .iic_wr_cnt_o(iic_wr_cnt_o),
    .iic_rd_cnt_o(iic_rd_cnt_o), .iic_mode_o(iic_mode_o), .iic_busy_i(iic_busy_i),
    .iic_rd_data_i(iic_rd_data_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic        is_to;
    logic [31:0] wr;
    logic [7:0]  wc;
    logic [7:0]  rc;
    logic        md;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] slave_rd_q[$];
  logic [31:0] cfg_wr[2];
  logic [7:0]  cfg_wc[2], cfg_rc[2];
  logic        cfg_md[2];
  int          rem_drv[2];
  int          n_cmp = 0, n_fail = 0;
  int          cyc = 0, launch_cyc = 0;
  logic        model_last = 1'b1;
  logic [31:0] model_rd = '0;
  logic [1:0]  prev_grant = 2'b00;
  exp_t        mon_e;
  logic [1:0]  mon_oh;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic rand_cfg();
    for (int n = 0; n < 2; n++) begin
      cfg_wr[n] = $urandom;
      cfg_wc[n] = 8'($urandom_range(1, 4));
      cfg_rc[n] = 8'($urandom_range(0, 4));
      cfg_md[n] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drive_cfg();
    req_wr_data = {cfg_wr[1], cfg_wr[0]};
    req_wr_cnt  = {cfg_wc[1], cfg_wc[0]};
    req_rd_cnt  = {cfg_rc[1], cfg_rc[0]};
    req_mode    = {cfg_md[1], cfg_md[0]};
  endtask

  function automatic exp_t mk_exp(input logic n, input logic to, input logic [31:0] rd);
    exp_t e;
    e.owner = n; e.is_to = to; e.wr = cfg_wr[n]; e.wc = cfg_wc[n];
    e.rc = cfg_rc[n]; e.md = cfg_md[n]; e.rd = rd;
    return e;
  endfunction

  // Waits for completion pulses and drops each request once its quota is served.
  task automatic wait_done(input int need);
    int seen = 0;
    int t = 0;
    while (seen < need && t < 3000) begin
      @(negedge clk);
      t++;
      for (int n = 0; n < 2; n++) begin
        if (done_o[n] || timeout_o[n]) begin
          seen++;
          rem_drv[n]--;
          if (rem_drv[n] <= 0) req_i[n] = 1'b0;
        end
      end
    end
    chk("completions", 64'(seen), 64'(need));
    repeat (4) @(negedge clk);
  endtask

  // Requesters with c0/c1 transactions each, all raised together while the arbiter is idle.
  task automatic run(input int c0, input int c1, input bit sil, input bit fix, input logic [31:0] rd_fix);
    int rem[2];
    logic n;
    exp_t e;
    rem[0] = c0; rem[1] = c1;
    silent = sil;
    drive_cfg();
    while (rem[0] + rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) n = ~model_last;
      else n = (rem[0] > 0) ? 1'b0 : 1'b1;
      e = mk_exp(n, sil, fix ? rd_fix : 32'($urandom));
      exp_q.push_back(e);
      if (!sil) slave_rd_q.push_back(e.rd);
      rem[n]--;
      model_last = n;
    end
    rem_drv[0] = c0; rem_drv[1] = c1;
    @(negedge clk);
    req_i = {c1 > 0, c0 > 0};
    wait_done(c0 + c1);
  endtask

  // Behavioural I2C master: busy rises a little after enable, falls once read data is in place.
  initial begin
    slv_busy = 1'b0;
    iic_rd_data_i = '0;
    forever begin
      @(negedge clk);
      if (!manual && !silent && rstn && iic_en_o) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        slv_busy = 1'b1;
        if (iic_mode_o) repeat ($urandom_range(8, 16)) @(negedge clk);
        else repeat ($urandom_range(2, 8)) @(negedge clk);
        if (slave_rd_q.size() > 0) iic_rd_data_i = slave_rd_q.pop_front();
        @(negedge clk);
        slv_busy = 1'b0;
      end
    end
  end

  // Monitor: checks each new grant's payload and each completion against the scoreboard.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_grant = 2'b00;
    end else begin
      if (grant_o != 2'b00 && prev_grant == 2'b00) begin
        launch_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_grant: got %b expected none", grant_o);
        end else begin
          mon_e  = exp_q[0];
          mon_oh = mon_e.owner ? 2'b10 : 2'b01;
          chk("grant_owner", 64'(grant_o), 64'(mon_oh));
          chk("en_at_launch", 64'(iic_en_o), 64'(1));
          chk("iic_wr_data", 64'(iic_wr_data_o), 64'(mon_e.wr));
          chk("iic_wr_cnt", 64'(iic_wr_cnt_o), 64'(mon_e.wc));
          chk("iic_rd_cnt", 64'(iic_rd_cnt_o), 64'(mon_e.rc));
          chk("iic_mode", 64'(iic_mode_o), 64'(mon_e.md));
        end
      end
      prev_grant = grant_o;
      if (done_o != 2'b00 || timeout_o != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_completion: got done %b timeout %b expected none", done_o, timeout_o);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_oh = mon_e.owner ? 2'b10 : 2'b01;
          chk("done_vec", 64'(done_o), mon_e.is_to ? 64'(0) : 64'(mon_oh));
          chk("timeout_vec", 64'(timeout_o), mon_e.is_to ? 64'(mon_oh) : 64'(0));
          chk("grant_cleared", 64'(grant_o), 64'(0));
          chk("en_low_at_end", 64'(iic_en_o), 64'(0));
          if (mon_e.is_to) begin
            chk("timeout_latency", 64'(cyc - launch_cyc), 64'(TO));
            chk("rd_data_kept", 64'(rd_data_o), 64'(model_rd));
          end else begin
            chk("rd_data", 64'(rd_data_o), 64'(mon_e.rd));
            model_rd = mon_e.rd;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, t;
    bit bad;
    exp_t e;
    rand_cfg();
    drive_cfg();
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(grant_o), 64'(0));
    chk("rst_en", 64'(iic_en_o), 64'(0));
    chk("rst_wr", 64'({iic_wr_data_o, iic_wr_cnt_o, iic_rd_cnt_o}), 64'(0));
    chk("rst_pulses", 64'({done_o, timeout_o, iic_mode_o}), 64'(0));
    chk("rst_rd_data", 64'(rd_data_o), 64'(0));
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    rand_cfg(); run(1, 1, 0, 0, '0);
    rand_cfg(); cfg_wc[0] = 8'd3; cfg_rc[0] = 8'd0; cfg_md[0] = 1'b0; run(1, 0, 0, 0, '0);
    rand_cfg(); cfg_wc[0] = 8'd2; cfg_rc[0] = 8'd2; cfg_md[0] = 1'b1; run(1, 0, 0, 1, 32'h0000A55A);
    rand_cfg(); run(1, 0, 1, 0, '0);
    rand_cfg(); run(0, 1, 0, 0, '0);
    rand_cfg(); run(2, 1, 0, 0, '0);
    for (int i = 0; i < 20; i++) begin
      rand_cfg();
      c0 = int'($urandom_range(0, 2));
      c1 = int'($urandom_range(0, 2));
      if (c0 + c1 == 0) c0 = 1;
      run(c0, c1, 0, 0, '0);
    end
    rand_cfg(); run(0, 1, 1, 0, '0);

    // Reset while the master is busy, then release with busy still high.
    manual = 1'b1;
    silent = 1'b0;
    rand_cfg(); drive_cfg();
    exp_q.push_back(mk_exp(1'b0, 1'b0, '0));
    rem_drv[0] = 1; rem_drv[1] = 0;
    @(negedge clk);
    req_i = 2'b01;
    t = 0;
    while (!iic_en_o && t < 100) begin @(negedge clk); t++; end
    chk("launch_seen", 64'(iic_en_o), 64'(1));
    man_busy = 1'b1;
    repeat (6) @(negedge clk);
    chk("active_grant", 64'(grant_o), 64'(2'b01));
    chk("active_en_low", 64'(iic_en_o), 64'(0));
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_grant", 64'(grant_o), 64'(0));
    chk("async_en", 64'(iic_en_o), 64'(0));
    chk("async_wr", 64'({iic_wr_data_o, iic_wr_cnt_o, iic_rd_cnt_o}), 64'(0));
    chk("async_misc", 64'({done_o, timeout_o, iic_mode_o}), 64'(0));
    chk("async_rd_data", 64'(rd_data_o), 64'(0));
    exp_q.delete();
    slave_rd_q.delete();
    model_last = 1'b1;
    model_rd = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (grant_o != 2'b00) bad = 1'b1;
    end
    chk("no_grant_while_busy", 64'(bad), 64'(0));
    e = mk_exp(1'b0, 1'b0, 32'($urandom));
    exp_q.push_back(e);
    slave_rd_q.push_back(e.rd);
    man_busy = 1'b0;
    manual = 1'b0;
    wait_done(1);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
